// File: rtl/flit_uart_streamer_pkg.sv
// Shared types and constants for the flit-to-UART drain stage.
// Optional framing is selected by STREAMER_FRAME_EN.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package flit_uart_streamer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HDR,
        SEND,
        WAIT,
        CHK
    } streamer_state_t;

    localparam logic [7:0] STREAMER_HDR_BYTE = 8'hA5;
    localparam int BYTES_PER_FLIT = `DATA_WIDTH / 8;

    function automatic int bytes_per(input int width);
        return width / 8;
    endfunction

endpackage

// File: rtl/flit_uart_streamer_fifo.sv
// Flit buffer with extra-bit pointers; a push is refused whenever full,
// even when a pop happens in the same cycle.
module flit_fifo
    import flit_uart_streamer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     nreset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) &&
                     (wptr[AW-1:0] == rptr[AW-1:0]);
    assign count   = wptr - rptr;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/flit_uart_streamer.sv
// Drains ejected flits into a byte UART, MSB byte first, paced on tx_done.
// Define STREAMER_FRAME_EN to wrap each flit in 0xA5 header + XOR checksum.
module flit_uart_streamer
    import flit_uart_streamer_pkg::*;
#(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  flit_valid,
    input  logic [DATA_WIDTH-1:0] flit_data,
    output logic                  flit_ready,
    output logic [7:0]            tx_byte,
    output logic                  tx_send_en,
    input  logic                  tx_done,
    output logic                  busy,
    output logic                  overflow
);

    localparam int NB = bytes_per(DATA_WIDTH);
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;
    localparam int QW = $clog2(FIFO_DEPTH) + 1;

    streamer_state_t       state;
    logic [DATA_WIDTH-1:0] sreg;
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] fifo_rdata;
    logic [CW-1:0]         byte_cnt;
    logic [QW-1:0]         fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  pop;
    logic                  last_byte;
`ifdef STREAMER_FRAME_EN
    logic [7:0]            chk;
    streamer_state_t       src;
`endif

    flit_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .nreset (nreset),
        .push   (flit_valid),
        .wdata  (flit_data),
        .pop    (pop),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    assign flit_ready = !fifo_full;
    assign pop        = (state == LOAD);
    assign busy       = (state != IDLE) || (fifo_count != '0);
    assign last_byte  = (byte_cnt == CW'(NB - 1));
    assign shifted    = sreg << 8;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            overflow <= 1'b0;
        end else if (flit_valid && fifo_full) begin
            overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state      <= IDLE;
            sreg       <= '0;
            byte_cnt   <= '0;
            tx_byte    <= '0;
            tx_send_en <= 1'b0;
`ifdef STREAMER_FRAME_EN
            chk        <= '0;
            src        <= IDLE;
`endif
        end else begin
            tx_send_en <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    sreg       <= fifo_rdata;
                    byte_cnt   <= '0;
                    tx_send_en <= 1'b1;
`ifdef STREAMER_FRAME_EN
                    chk        <= '0;
                    tx_byte    <= STREAMER_HDR_BYTE;
                    state      <= HDR;
`else
                    tx_byte    <= fifo_rdata[DATA_WIDTH-1 -: 8];
                    state      <= SEND;
`endif
                end
                HDR, SEND, CHK: begin
`ifdef STREAMER_FRAME_EN
                    src <= state;
                    if (state == SEND) begin
                        chk <= chk ^ tx_byte;
                    end
`endif
                    state <= WAIT;
                end
                WAIT: begin
                    if (tx_done) begin
`ifdef STREAMER_FRAME_EN
                        if (src == HDR) begin
                            tx_byte    <= sreg[DATA_WIDTH-1 -: 8];
                            tx_send_en <= 1'b1;
                            state      <= SEND;
                        end else if (src == CHK) begin
                            state <= fifo_empty ? IDLE : LOAD;
                        end else if (last_byte) begin
                            tx_byte    <= chk;
                            tx_send_en <= 1'b1;
                            state      <= CHK;
                        end else begin
                            sreg       <= shifted;
                            byte_cnt   <= byte_cnt + 1'b1;
                            tx_byte    <= shifted[DATA_WIDTH-1 -: 8];
                            tx_send_en <= 1'b1;
                            state      <= SEND;
                        end
`else
                        if (last_byte) begin
                            state <= fifo_empty ? IDLE : LOAD;
                        end else begin
                            sreg       <= shifted;
                            byte_cnt   <= byte_cnt + 1'b1;
                            tx_byte    <= shifted[DATA_WIDTH-1 -: 8];
                            tx_send_en <= 1'b1;
                            state      <= SEND;
                        end
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flit_uart_streamer.sv
// Scoreboard bench for flit_uart_streamer with a paced UART transmitter model.
// Expected bytes are queued at stimulus time and popped on each tx_send_en.
module tb_flit_uart_streamer;
    import flit_uart_streamer_pkg::*;

    localparam int DW = 32;
    localparam int NB = DW / 8;
`ifdef STREAMER_FRAME_EN
    localparam int NTX = NB + 2;
`else
    localparam int NTX = NB;
`endif

    logic          clk = 1'b0;
    logic          nreset = 1'b0;
    logic          flit_valid = 1'b0;
    logic [DW-1:0] flit_data = '0;
    logic          flit_ready;
    logic [7:0]    tx_byte;
    logic          tx_send_en;
    logic          busy;
    logic          overflow;
    logic          model_done = 1'b0;
    logic          spur_done = 1'b0;
    wire           tx_done = model_done | spur_done;

    flit_uart_streamer #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .nreset     (nreset),
        .flit_valid (flit_valid),
        .flit_data  (flit_data),
        .flit_ready (flit_ready),
        .tx_byte    (tx_byte),
        .tx_send_en (tx_send_en),
        .tx_done    (tx_done),
        .busy       (busy),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    logic [7:0] exp_q[$];
    int         send_log[$];
    logic [7:0] last_sent = 8'h00;
    logic       prev_send = 1'b0;
    logic       prev_busy = 1'b0;
    int         busy_fall_cyc = -1;
    int         done_cyc = -1;
    int         n_done = 0;
    logic       auto_tx = 1'b1;
    logic       pending = 1'b0;
    int         cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every start pulse must carry the next expected byte.
    always @(negedge clk) begin
        if (nreset && tx_send_en) begin
            check("send_pulse_width", {63'd0, prev_send}, 64'd0);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_byte: got %0h, expected none", tx_byte);
            end else begin
                check("tx_byte", {56'd0, tx_byte}, {56'd0, exp_q.pop_front()});
            end
            last_sent = tx_byte;
            send_log.push_back(cyc);
        end
        prev_send = tx_send_en;
        if (nreset && prev_busy && !busy) busy_fall_cyc = cyc;
        prev_busy = busy;
    end

    // Transmitter model: answers each start pulse with a one-cycle done.
    always @(negedge clk) begin
        if (!nreset) begin
            model_done = 1'b0;
            pending = 1'b0;
            cnt = 0;
        end else begin
            if (model_done) begin
                model_done = 1'b0;
                n_done++;
                done_cyc = cyc;
            end
            if (pending) begin
                if (cnt > 0) begin
                    cnt--;
                end else if (auto_tx) begin
                    check("tx_byte_stable", {56'd0, tx_byte}, {56'd0, last_sent});
                    model_done = 1'b1;
                    pending = 1'b0;
                end
            end
            if (tx_send_en) begin
                pending = 1'b1;
                cnt = 2;
            end
        end
    end

    task automatic push_exp(input logic [DW-1:0] d);
`ifdef STREAMER_FRAME_EN
        logic [7:0] c;
        c = 8'h00;
        exp_q.push_back(8'hA5);
`endif
        for (int i = NB - 1; i >= 0; i--) begin
            exp_q.push_back(d[i*8 +: 8]);
`ifdef STREAMER_FRAME_EN
            c = c ^ d[i*8 +: 8];
`endif
        end
`ifdef STREAMER_FRAME_EN
        exp_q.push_back(c);
`endif
    endtask

    task automatic offer(input logic [DW-1:0] d);
        flit_valid = 1'b1;
        flit_data = d;
        @(negedge clk);
        flit_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_timeout"}, {63'd0, n >= 3000}, 64'd0);
        @(negedge clk);
    endtask

    task automatic wait_load(input string name);
        int n;
        n = 0;
        while (dut.state != LOAD && n < 500) begin
            @(negedge clk);
            n++;
        end
        check({name, "_timeout"}, {63'd0, n >= 500}, 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_byte"}, {56'd0, tx_byte}, 64'h00);
        check({tag, "_send_en"}, {63'd0, tx_send_en}, 64'd0);
        check({tag, "_flit_ready"}, {63'd0, flit_ready}, 64'd1);
        check({tag, "_busy"}, {63'd0, busy}, 64'd0);
        check({tag, "_overflow"}, {63'd0, overflow}, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_cyc;
        int n;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        nreset = 1'b1;
        @(negedge clk);

        // Single flit: latency, ordering, busy drop.
        send_log.delete();
        push_exp(32'h1234_ABCD);
        flit_valid = 1'b1;
        flit_data = 32'h1234_ABCD;
        @(negedge clk);
        acc_cyc = cyc;
        flit_valid = 1'b0;
        wait_idle("single");
        check("single_pulses", send_log.size(), NTX);
        if (send_log.size() > 0) begin
            check("first_pulse_latency", send_log[0] - acc_cyc, 2);
        end
        check("busy_fall", busy_fall_cyc, done_cyc);

        // Five flits with tx_done withheld, sixth refused.
        auto_tx = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_exp(32'h1000_0000 * (i + 1) + 32'h0001_0203 * i);
            offer(32'h1000_0000 * (i + 1) + 32'h0001_0203 * i);
        end
        check("full_ready_low", {63'd0, flit_ready}, 64'd0);
        offer(32'hEEEE_EEEE);
        check("overflow_set", {63'd0, overflow}, 64'd1);
        check("occ_full", {61'd0, dut.u_fifo.count}, 64'd4);

        // Push during pop at occupancy 4 is refused.
        auto_tx = 1'b1;
        wait_load("load_a");
        offer(32'h7777_7777);
        check("occ_pushpop_full", {61'd0, dut.u_fifo.count}, 64'd3);
        wait_load("load_b");
        @(negedge clk);
        check("occ_after_pop", {61'd0, dut.u_fifo.count}, 64'd2);
        // Push during pop at occupancy 2 leaves it at 2.
        wait_load("load_c");
        push_exp(32'h5A5A_0FF0);
        offer(32'h5A5A_0FF0);
        check("occ_pushpop_mid", {61'd0, dut.u_fifo.count}, 64'd2);
        wait_idle("burst");
        check("overflow_sticky", {63'd0, overflow}, 64'd1);

        // Spurious tx_done while idle and during SEND.
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        check("spur_idle_send_en", {63'd0, tx_send_en}, 64'd0);
        check("spur_idle_busy", {63'd0, busy}, 64'd0);
        send_log.delete();
        push_exp(32'hC0FF_EE11);
        offer(32'hC0FF_EE11);
        n = 0;
        while (!tx_send_en && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("spur_send_timeout", {63'd0, n >= 50}, 64'd0);
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        wait_idle("spur");
        check("spur_pulses", send_log.size(), NTX);

        // Reset mid-flit abandons everything.
        push_exp(32'hDEAD_BEEF);
        offer(32'hDEAD_BEEF);
        push_exp(32'h1111_1111);
        offer(32'h1111_1111);
        push_exp(32'h2222_2222);
        offer(32'h2222_2222);
        n = 0;
        acc_cyc = n_done;
        while (n_done < acc_cyc + 2 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("reset_wait_timeout", {63'd0, n >= 500}, 64'd0);
        #1;
        nreset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("midreset");
        nreset = 1'b1;
        @(negedge clk);
        push_exp(32'h0000_0001);
        offer(32'h0000_0001);
        wait_idle("after_reset");
        check("after_reset_drained", exp_q.size(), 0);

`ifdef STREAMER_FRAME_EN
        send_log.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h03);
        exp_q.push_back(8'h04);
        exp_q.push_back(8'h04);
        offer(32'h0102_0304);
        wait_idle("framed");
        check("framed_pulses", send_log.size(), 6);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
